// File: rtl/cordic_scheduler.sv
// cordic_scheduler: two-requester front end for one iterative CORDIC
// engine. Arbitrates, latches operands, times the engine, returns result.
//   clk, rst          : clock, synchronous active-high reset
//   reqN_valid/ready  : requester handshakes, reqN_x0/y0/z0 operands
//   cfg_n             : iteration count, sampled at accept, clamped
//   eng_valid, eng_*0 : start pulse and latched operands to the engine
//   eng_n             : clamped iteration count to the engine
//   eng_x/y/z         : engine results
//   rsp_valid/ready   : response handshake, rsp_id + rsp_x/y/z payload
// Build option: CORDIC_SCHED_RR_EN selects round-robin arbitration;
// without it req0 has fixed priority.
module cordic_scheduler #(
  parameter int W             = 32,
  parameter int MAX_ITER      = 16,
  parameter int ENG_LAT_EXTRA = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_x0,
  input  logic [W-1:0] req0_y0,
  input  logic [W-1:0] req0_z0,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_x0,
  input  logic [W-1:0] req1_y0,
  input  logic [W-1:0] req1_z0,
  input  logic [W-1:0] cfg_n,
  output logic         eng_valid,
  output logic [W-1:0] eng_x0,
  output logic [W-1:0] eng_y0,
  output logic [W-1:0] eng_z0,
  output logic [W-1:0] eng_n,
  input  logic [W-1:0] eng_x,
  input  logic [W-1:0] eng_y,
  input  logic [W-1:0] eng_z,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_x,
  output logic [W-1:0] rsp_y,
  output logic [W-1:0] rsp_z
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RUN,
    RESP
  } state_t;

  state_t       state;
  state_t       state_nx;
  logic         ptr;
  logic         gnt;
  logic         any_valid;
  logic         idle_ok;
  logic         accept;
  logic [W-1:0] n_clamp;
  logic [W-1:0] cnt;

  // Tie goes to the pointer; a lone request wins regardless.
  always_comb begin
    if (req0_valid && req1_valid) gnt = ptr;
    else                          gnt = req1_valid;
  end

  assign any_valid  = req0_valid | req1_valid;
  // Ready is forced low while reset is asserted.
  assign idle_ok    = (state == IDLE) && !rst && any_valid;
  assign req0_ready = idle_ok && !gnt;
  assign req1_ready = idle_ok && gnt;
  assign accept     = (req0_ready && req0_valid) ||
                      (req1_ready && req1_valid);

  always_comb begin
    if (cfg_n == '0)
      n_clamp = W'(1);
    else if (cfg_n > W'(MAX_ITER))
      n_clamp = W'(MAX_ITER);
    else
      n_clamp = cfg_n;
  end

  always_comb begin
    state_nx  = state;
    eng_valid = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = ISSUE;
      end
      ISSUE: begin
        eng_valid = 1'b1;
        state_nx  = RUN;
      end
      RUN: begin
        if (cnt == W'(1)) state_nx = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      eng_x0 <= '0;
      eng_y0 <= '0;
      eng_z0 <= '0;
      eng_n  <= W'(1);
      rsp_id <= 1'b0;
      rsp_x  <= '0;
      rsp_y  <= '0;
      rsp_z  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        eng_x0 <= gnt ? req1_x0 : req0_x0;
        eng_y0 <= gnt ? req1_y0 : req0_y0;
        eng_z0 <= gnt ? req1_z0 : req0_z0;
        eng_n  <= n_clamp;
        rsp_id <= gnt;
      end
      if (state == ISSUE)
        cnt <= eng_n + W'(ENG_LAT_EXTRA);
      if (state == RUN) begin
        cnt <= cnt - W'(1);
        // Engine output is stable in the last counted cycle.
        if (cnt == W'(1)) begin
          rsp_x <= eng_x;
          rsp_y <= eng_y;
          rsp_z <= eng_z;
        end
      end
    end
  end

`ifdef CORDIC_SCHED_RR_EN
  // Next tie goes to whoever was not just served.
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= 1'b0;
    else if (state == RESP && rsp_ready)
      ptr <= ~rsp_id;
  end
`else
  assign ptr = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_scheduler.sv
// tb_cordic_scheduler: randomized self-checking bench with engine stub
// and a transaction-level reference model of arbitration and timing.
module tb_cordic_scheduler;

  localparam int W     = 32;
  localparam int MAXI  = 16;
  localparam int EXTRA = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready;
  logic [W-1:0] req0_x0, req0_y0, req0_z0;
  logic         req1_valid, req1_ready;
  logic [W-1:0] req1_x0, req1_y0, req1_z0;
  logic [W-1:0] cfg_n;
  logic         eng_valid;
  logic [W-1:0] eng_x0, eng_y0, eng_z0, eng_n;
  logic [W-1:0] eng_x, eng_y, eng_z;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0] rsp_x, rsp_y, rsp_z;

  int  checks = 0;
  int  errors = 0;
  bit  mptr   = 1'b0;

  always #5 clk = ~clk;

  cordic_scheduler #(
    .W(W), .MAX_ITER(MAXI), .ENG_LAT_EXTRA(EXTRA)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_x0(req0_x0), .req0_y0(req0_y0), .req0_z0(req0_z0),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_x0(req1_x0), .req1_y0(req1_y0), .req1_z0(req1_z0),
    .cfg_n(cfg_n),
    .eng_valid(eng_valid),
    .eng_x0(eng_x0), .eng_y0(eng_y0), .eng_z0(eng_z0),
    .eng_n(eng_n),
    .eng_x(eng_x), .eng_y(eng_y), .eng_z(eng_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z)
  );

  // Engine stub: result valid n+1 cycles after the start pulse,
  // deliberately wrong before that.
  logic [7:0] sk = 8'hff;
  always @(posedge clk) begin
    if (eng_valid)        sk <= 8'd1;
    else if (sk != 8'hff) sk <= sk + 8'd1;
  end
  wire ok = (32'(sk) >= eng_n + 32'd1);
  assign eng_x = ok ? eng_x0 + 32'd1 : ~eng_x0;
  assign eng_y = ok ? eng_y0 + 32'd2 : ~eng_y0;
  assign eng_z = ok ? eng_z0 + 32'd3 : ~eng_z0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int clampf(input logic [31:0] n);
    if (n == 0)    return 1;
    if (n > MAXI)  return MAXI;
    return int'(n);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    @(negedge clk);
    rst  = 1'b0;
    mptr = 1'b0;
  endtask

  task automatic run_op(input bit v0, input bit v1,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] z, input logic [31:0] n,
                        input int hold, output bit id);
    logic [31:0] ex, ey, ez;
    bit w, busy_ok, stab_ok;
    int k, lat, en;
    @(negedge clk);
    rsp_ready  = 1'b0;
    req0_valid = v0;
    req1_valid = v1;
    req0_x0 = x;
    req0_y0 = y;
    req0_z0 = z;
    req1_x0 = x ^ 32'h5a5a_1234;
    req1_y0 = y + 32'd77;
    req1_z0 = ~z;
    cfg_n = n;
    w  = (v0 && v1) ? mptr : v1;
    ex = w ? req1_x0 : req0_x0;
    ey = w ? req1_y0 : req0_y0;
    ez = w ? req1_z0 : req0_z0;
    en = clampf(n);
    #1;
    check("ready_win", w ? req1_ready : req0_ready, 1);
    check("ready_lose", w ? req0_ready : req1_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cfg_n = $urandom;
    check("eng_valid", eng_valid, 1);
    check("eng_n", eng_n, en);
    check("eng_x0", eng_x0, ex);
    check("eng_y0", eng_y0, ey);
    check("eng_z0", eng_z0, ez);
    k = 1;
    lat = -1;
    busy_ok = 1'b1;
    while (k < 100) begin
      @(negedge clk);
      k++;
      req0_valid = 1'($urandom);
      req1_valid = 1'($urandom);
      req0_x0 = $urandom;
      req1_x0 = $urandom;
      #1;
      if (req0_ready || req1_ready || eng_valid) busy_ok = 1'b0;
      if (eng_x0 !== ex || eng_n !== 32'(en))    busy_ok = 1'b0;
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    check("latency", lat, en + 2 + EXTRA);
    check("busy_block", busy_ok, 1);
    check("rsp_id", rsp_id, w);
    check("rsp_x", rsp_x, ex + 32'd1);
    check("rsp_y", rsp_y, ey + 32'd2);
    check("rsp_z", rsp_z, ez + 32'd3);
    stab_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      req0_valid = 1'($urandom);
      req1_valid = 1'($urandom);
      #1;
      if (!rsp_valid || rsp_id !== w || rsp_x !== ex + 32'd1 ||
          rsp_y !== ey + 32'd2 || rsp_z !== ez + 32'd3 ||
          req0_ready || req1_ready || eng_x0 !== ex)
        stab_ok = 1'b0;
    end
    if (hold > 0) check("rsp_stable", stab_ok, 1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
`ifdef CORDIC_SCHED_RR_EN
    mptr = ~w;
`endif
    id = w;
  endtask

  initial begin
    bit id;
    bit ids[4];
    bit exp_ids[4];
    bit seen;
    logic [31:0] rn;
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_x0 = 0; req0_y0 = 0; req0_z0 = 0;
    req1_x0 = 0; req1_y0 = 0; req1_z0 = 0;
    cfg_n = 32'd5;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_eng_valid", eng_valid, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_x", {rsp_x, rsp_y}, 0);
    check("rst_rsp_z", rsp_z, 0);
    check("rst_eng_x0", {eng_x0, eng_y0}, 0);
    check("rst_eng_z0", eng_z0, 0);
    check("rst_eng_n", eng_n, 1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;

    run_op(1, 0, 32'd65536, 32'd0, 32'd102943, 32'd16, 0, id);
    check("single_rsp_x", rsp_x, 32'd65537);
    check("single_rsp_z", rsp_z, 32'd102946);
    run_op(1, 0, $urandom, $urandom, $urandom, 32'd0, 0, id);
    run_op(0, 1, $urandom, $urandom, $urandom, 32'd40, 0, id);

    do_reset();
`ifdef CORDIC_SCHED_RR_EN
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 4; i++) begin
      run_op(1, 1, $urandom, $urandom, $urandom, 32'd3, 0, id);
      ids[i] = id;
      check("contention_id", rsp_id, exp_ids[i]);
    end

    run_op(1, 0, $urandom, $urandom, $urandom, 32'd5, 10, id);
    run_op(0, 1, $urandom, $urandom, $urandom, 32'd2, 0, id);

    // Reset in the middle of an n=16 operation.
    @(negedge clk);
    rsp_ready  = 1'b0;
    req0_valid = 1'b1;
    req0_x0 = 32'h1234_5678;
    cfg_n = 32'd16;
    @(negedge clk);
    req0_valid = 1'b0;
    check("mid_eng_valid", eng_valid, 1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_eng_n", eng_n, 1);
    check("mid_rst_eng_x0", eng_x0, 0);
    check("mid_rst_rsp", {rsp_valid, eng_valid, req0_ready}, 0);
    rst  = 1'b0;
    mptr = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("mid_rst_no_rsp", seen, 0);

    for (int i = 0; i < 30; i++) begin
      bit v0, v1;
      v0 = 1'($urandom);
      v1 = v0 ? 1'($urandom) : 1'b1;
      rn = ($urandom_range(0, 7) == 0) ? 32'd40 : $urandom_range(0, 18);
      run_op(v0, v1, $urandom, $urandom, $urandom, rn,
             $urandom_range(0, 3), id);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_scheduler.md
# cordic_scheduler

Two-requester scheduler in front of the single iterative `cordic_block` engine. It arbitrates between two operand sources and latches the winner's x0/y0/z0 and iteration count. It pulses the engine's `valid` and counts out the engine latency. It returns the captured x/y/z result with a requester tag over a valid/ready response port. One operation is in flight at a time.

## Interface
Parameters:
- `W`, 32: operand/result width (Q16.16; 65536 = 1.0, 102943 ≈ π/2)
- `MAX_ITER`, 16: upper clamp for iteration count
- `ENG_LAT_EXTRA`, 1: engine cycles beyond `n` from start pulse to stable result

Ports:
- `clk` in 1: single clock, all logic rising-edge
- `rst` in 1: reset, synchronous, active-high
- `req0_valid` in 1 / `req0_ready` out 1: requester 0 handshake
- `req0_x0`, `req0_y0`, `req0_z0` in W: requester 0 operands
- `req1_valid` in 1 / `req1_ready` out 1: requester 1 handshake
- `req1_x0`, `req1_y0`, `req1_z0` in W: requester 1 operands
- `cfg_n` in W: iteration count, sampled at accept
- `eng_valid` out 1: one-cycle start pulse to engine
- `eng_x0`, `eng_y0`, `eng_z0`, `eng_n` out W: latched operands and clamped count to engine
- `eng_x`, `eng_y`, `eng_z` in W: engine results
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake
- `rsp_id` out 1: requester that issued the op
- `rsp_x`, `rsp_y`, `rsp_z` out W: captured results

## Operation
- FSM states: IDLE → ISSUE → RUN → RESP → IDLE.
- IDLE: grant is combinational from `reqN_valid` and the priority pointer. `reqN_ready` is high only in IDLE, only for the granted requester. When valid && ready, latch operands, `rsp_id`, and clamped n, then go to ISSUE.
- Clamp: `cfg_n`==0 → 1; `cfg_n` > MAX_ITER → MAX_ITER; otherwise unchanged.
- ISSUE: `eng_valid`=1 for exactly this cycle. Load counter = `eng_n`+ENG_LAT_EXTRA. Go to RUN.
- RUN: decrement counter each cycle. In the cycle the counter is 1, capture `eng_x/y/z` into `rsp_x/y/z` and go to RESP.
- RESP: `rsp_valid`=1 and held stable until `rsp_ready`. On handshake, update the pointer and go to IDLE.
- Both requests valid in IDLE: pointer decides. One valid: that one wins regardless of pointer.
- Requests in ISSUE/RUN/RESP: both ready low; the request waits, nothing is latched.
- `reqN_valid` dropped before grant: no effect.
- `eng_x0/y0/z0/n` hold the latched values from accept until the next accept.

## Timing
- Reset values: `req0_ready`=`req1_ready`=0 during reset, `eng_valid`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_x/y/z`=0, `eng_x0/y0/z0`=0, `eng_n`=1, pointer=req0, state IDLE.
- Accept at cycle T: `eng_valid` high at T+1; result captured at T+1+n+ENG_LAT_EXTRA; `rsp_valid` high from T+2+n+ENG_LAT_EXTRA.
- Example: n=16, EXTRA=1 gives `rsp_valid` at T+19.
- Back-to-back: `rsp_ready` high in first RESP cycle → IDLE next cycle → next accept possible that cycle. Minimum spacing between accepts is n+EXTRA+3 cycles.
- Reset mid-operation (ISSUE/RUN/RESP): next cycle is IDLE with reset values. The in-flight result is discarded and no response is produced.

## Configuration
- `CORDIC_SCHED_RR_EN` defined: round-robin. After each response handshake, the pointer moves to the requester other than `rsp_id`.
- Undefined: fixed priority. req0 always wins a tie, and the pointer is constant req0.
- Ports and timing are identical in both builds.

## Test plan
All tests run against a behavioural engine stub. The stub returns x=x0+1, y=y0+2, z=z0+3, stable n+1 cycles after `eng_valid`.

- Single op: reset, req0 x0=65536 y0=0 z0=102943, `cfg_n`=16, accept at T → `eng_valid` pulse at T+1 with `eng_n`=16. `rsp_valid` at T+19, `rsp_id`=0, `rsp_x`=65537, `rsp_y`=2, `rsp_z`=102946.
- Clamp: `cfg_n`=0 → `eng_n`=1, `rsp_valid` at T+4. `cfg_n`=40 → `eng_n`=16.
- Contention with RR_EN: both valid continuously for 4 ops → `rsp_id` sequence 0,1,0,1. Without RR_EN → 0,0,0,0.
- Backpressure: hold `rsp_ready`=0 for 10 cycles in RESP → `rsp_*` stable, both ready low, a pending req1 is not accepted until the cycle after the handshake.
- Reset mid-RUN: assert `rsp_valid`... no; assert `rst` at T+5 of an n=16 op → all outputs at reset values the next cycle, and no `rsp_valid` ever appears for that op.
- Busy blocking: req1 raises valid during RUN → `req1_ready` stays 0 and `eng_x0` is unchanged until IDLE.
